inst_encoder: RTL and testbench



---
 rtl/inst_encoder.sv | 238 +++++++++++++++++++++++
 tb/tb_inst_encoder.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/inst_encoder.sv
// inst_encoder: streaming RV32I instruction encoder (inverse of the decoder).
// Decoded fields enter a small FIFO over valid/ready. Each entry is popped and
// assembled into a 32-bit word. The word is then written little-endian, one
// byte per cycle, to sequential addresses.
// Ports:
//   clk_in, rst_in (async, active-high), rdy_in (global pause)
//   start/base_addr          : restart at a new address, clear count/err, flush
//   in_valid/in_ready, op_type, rd, rs1, rs2, imm : decoded instruction input
//   mem_wr/mem_a/mem_dout    : byte-wide memory write port
//   busy, err (sticky unencodable op), count (words written, wraps)
module inst_encoder #(
  parameter int FIFO_DEPTH = 2
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        rdy_in,
  input  logic        start,
  input  logic [31:0] base_addr,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [5:0]  op_type,
  input  logic [4:0]  rd,
  input  logic [4:0]  rs1,
  input  logic [4:0]  rs2,
  input  logic [31:0] imm,
  output logic        mem_wr,
  output logic [31:0] mem_a,
  output logic [7:0]  mem_dout,
  output logic        busy,
  output logic        err,
  output logic [15:0] count
);
  localparam int AW = $clog2(FIFO_DEPTH);

  // OP_* codes shared with the decoder
  localparam logic [5:0] OP_LUI  = 6'd1,  OP_AUIPC = 6'd2,  OP_JAL  = 6'd3,  OP_JALR = 6'd4;
  localparam logic [5:0] OP_BEQ  = 6'd5,  OP_BNE   = 6'd6,  OP_BLT  = 6'd7,  OP_BGE  = 6'd8;
  localparam logic [5:0] OP_BLTU = 6'd9,  OP_BGEU  = 6'd10, OP_LB   = 6'd11, OP_LH   = 6'd12;
  localparam logic [5:0] OP_LW   = 6'd13, OP_LBU   = 6'd14, OP_LHU  = 6'd15, OP_SB   = 6'd16;
  localparam logic [5:0] OP_SH   = 6'd17, OP_SW    = 6'd18, OP_ADDI = 6'd19, OP_SLTI = 6'd20;
  localparam logic [5:0] OP_SLTIU= 6'd21, OP_XORI  = 6'd22, OP_ORI  = 6'd23, OP_ANDI = 6'd24;
  localparam logic [5:0] OP_SLLI = 6'd25, OP_SRLI  = 6'd26, OP_SRAI = 6'd27, OP_ADD  = 6'd28;
  localparam logic [5:0] OP_SUB  = 6'd29, OP_SLL   = 6'd30, OP_SLT  = 6'd31, OP_SLTU = 6'd32;
  localparam logic [5:0] OP_XOR  = 6'd33, OP_SRL   = 6'd34, OP_SRA  = 6'd35, OP_OR   = 6'd36;
  localparam logic [5:0] OP_AND  = 6'd37;

  localparam logic [6:0] OPC_LUI = 7'b0110111, OPC_AUIPC = 7'b0010111, OPC_JAL = 7'b1101111;
  localparam logic [6:0] OPC_JALR = 7'b1100111, OPC_BR = 7'b1100011, OPC_LD = 7'b0000011;
  localparam logic [6:0] OPC_ST = 7'b0100011, OPC_IMM = 7'b0010011, OPC_REG = 7'b0110011;

  typedef enum logic [2:0] {F_R, F_I, F_SH, F_S, F_B, F_U, F_J} fmt_t;
  typedef enum logic [2:0] {S_IDLE, S_W0, S_W1, S_W2, S_W3} state_t;

  typedef struct packed {
    logic [5:0]  op;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [31:0] imm;
  } entry_t;

  state_t        state_q, state_d;
  logic [31:0]   waddr_q, waddr_d, word_q, word_d;
  logic [15:0]   count_q, count_d;
  logic          err_q, err_d;
  logic [AW:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  entry_t        fifo_mem_q [FIFO_DEPTH];
  entry_t        head;
  logic          empty, full, push;
  logic [6:0]    opc;
  logic [2:0]    f3;
  logic          alt;     // funct7 = 0100000 (SUB/SRA/SRAI)
  logic          enc_ok;
  fmt_t          fmt;
  logic [31:0]   enc_word;
  logic [1:0]    byte_idx;

  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  assign empty    = (wr_ptr_q == rd_ptr_q);
  assign full     = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  // Occupancy is taken before this cycle's pop, so a full FIFO never pushes.
  assign in_ready = !full && !start && rdy_in;
  assign push     = in_valid && in_ready;
  assign head     = fifo_mem_q[rd_ptr_q[AW-1:0]];

  always_ff @(posedge clk_in) begin
    if (push) fifo_mem_q[wr_ptr_q[AW-1:0]] <= '{op_type, rd, rs1, rs2, imm};
  end

  // Per-op opcode/funct3/format lookup
  always_comb begin
    opc = '0; f3 = '0; alt = 1'b0; fmt = F_I; enc_ok = 1'b1;
    case (head.op)
      OP_LUI:   begin fmt = F_U;  opc = OPC_LUI;   end
      OP_AUIPC: begin fmt = F_U;  opc = OPC_AUIPC; end
      OP_JAL:   begin fmt = F_J;  opc = OPC_JAL;   end
      OP_JALR:  begin fmt = F_I;  opc = OPC_JALR;  end
      OP_BEQ:   begin fmt = F_B;  opc = OPC_BR;  f3 = 3'd0; end
      OP_BNE:   begin fmt = F_B;  opc = OPC_BR;  f3 = 3'd1; end
      OP_BLT:   begin fmt = F_B;  opc = OPC_BR;  f3 = 3'd4; end
      OP_BGE:   begin fmt = F_B;  opc = OPC_BR;  f3 = 3'd5; end
      OP_BLTU:  begin fmt = F_B;  opc = OPC_BR;  f3 = 3'd6; end
      OP_BGEU:  begin fmt = F_B;  opc = OPC_BR;  f3 = 3'd7; end
      OP_LB:    begin fmt = F_I;  opc = OPC_LD;  f3 = 3'd0; end
      OP_LH:    begin fmt = F_I;  opc = OPC_LD;  f3 = 3'd1; end
      OP_LW:    begin fmt = F_I;  opc = OPC_LD;  f3 = 3'd2; end
      OP_LBU:   begin fmt = F_I;  opc = OPC_LD;  f3 = 3'd4; end
      OP_LHU:   begin fmt = F_I;  opc = OPC_LD;  f3 = 3'd5; end
      OP_SB:    begin fmt = F_S;  opc = OPC_ST;  f3 = 3'd0; end
      OP_SH:    begin fmt = F_S;  opc = OPC_ST;  f3 = 3'd1; end
      OP_SW:    begin fmt = F_S;  opc = OPC_ST;  f3 = 3'd2; end
      OP_ADDI:  begin fmt = F_I;  opc = OPC_IMM; f3 = 3'd0; end
      OP_SLTI:  begin fmt = F_I;  opc = OPC_IMM; f3 = 3'd2; end
      OP_SLTIU: begin fmt = F_I;  opc = OPC_IMM; f3 = 3'd3; end
      OP_XORI:  begin fmt = F_I;  opc = OPC_IMM; f3 = 3'd4; end
      OP_ORI:   begin fmt = F_I;  opc = OPC_IMM; f3 = 3'd6; end
      OP_ANDI:  begin fmt = F_I;  opc = OPC_IMM; f3 = 3'd7; end
      OP_SLLI:  begin fmt = F_SH; opc = OPC_IMM; f3 = 3'd1; end
      OP_SRLI:  begin fmt = F_SH; opc = OPC_IMM; f3 = 3'd5; end
      OP_SRAI:  begin fmt = F_SH; opc = OPC_IMM; f3 = 3'd5; alt = 1'b1; end
      OP_ADD:   begin fmt = F_R;  opc = OPC_REG; f3 = 3'd0; end
      OP_SUB:   begin fmt = F_R;  opc = OPC_REG; f3 = 3'd0; alt = 1'b1; end
      OP_SLL:   begin fmt = F_R;  opc = OPC_REG; f3 = 3'd1; end
      OP_SLT:   begin fmt = F_R;  opc = OPC_REG; f3 = 3'd2; end
      OP_SLTU:  begin fmt = F_R;  opc = OPC_REG; f3 = 3'd3; end
      OP_XOR:   begin fmt = F_R;  opc = OPC_REG; f3 = 3'd4; end
      OP_SRL:   begin fmt = F_R;  opc = OPC_REG; f3 = 3'd5; end
      OP_SRA:   begin fmt = F_R;  opc = OPC_REG; f3 = 3'd5; alt = 1'b1; end
      OP_OR:    begin fmt = F_R;  opc = OPC_REG; f3 = 3'd6; end
      OP_AND:   begin fmt = F_R;  opc = OPC_REG; f3 = 3'd7; end
      default:  enc_ok = 1'b0;  // OP_NULL and unassigned codes
    endcase
  end

  // Field assembly; register slots a format lacks are simply not emitted (0).
  always_comb begin
    enc_word = '0;
    case (fmt)
      F_R:  enc_word = {1'b0, alt, 5'd0, head.rs2, head.rs1, f3, head.rd, opc};
      F_I:  enc_word = {head.imm[11:0], head.rs1, f3, head.rd, opc};
      F_SH: enc_word = {1'b0, alt, 5'd0, head.imm[4:0], head.rs1, f3, head.rd, opc};
      F_S:  enc_word = {head.imm[11:5], head.rs2, head.rs1, f3, head.imm[4:0], opc};
      F_B:  enc_word = {head.imm[12], head.imm[10:5], head.rs2, head.rs1, f3,
                        head.imm[4:1], head.imm[11], opc};
      F_U:  enc_word = {head.imm[31:12], head.rd, opc};
      F_J:  enc_word = {head.imm[20], head.imm[10:1], head.imm[11], head.imm[19:12],
                        head.rd, opc};
      default: enc_word = '0;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    waddr_d  = waddr_q;
    word_d   = word_q;
    count_d  = count_q;
    err_d    = err_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (start) begin
      // push is blocked while start is high, so rd=wr empties the FIFO
      state_d  = S_IDLE;
      waddr_d  = base_addr;
      count_d  = '0;
      err_d    = 1'b0;
      rd_ptr_d = wr_ptr_q;
    end else if (rdy_in) begin
      if (push) wr_ptr_d = wr_ptr_q + PTR_ONE;
      case (state_q)
        S_W0: state_d = S_W1;
        S_W1: state_d = S_W2;
        S_W2: state_d = S_W3;
        default: begin  // IDLE or W3
          if (state_q == S_W3) begin
            waddr_d = waddr_q + 32'd4;
            count_d = count_q + 16'd1;
          end
          state_d = S_IDLE;
          if (!empty) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
            if (enc_ok) begin
              word_d  = enc_word;
              state_d = S_W0;
            end else begin
              err_d = 1'b1;
            end
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_q  <= S_IDLE;
      waddr_q  <= '0;
      word_q   <= '0;
      count_q  <= '0;
      err_q    <= 1'b0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      state_q  <= state_d;
      waddr_q  <= waddr_d;
      word_q   <= word_d;
      count_q  <= count_d;
      err_q    <= err_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_comb begin
    case (state_q)
      S_W1:    byte_idx = 2'd1;
      S_W2:    byte_idx = 2'd2;
      S_W3:    byte_idx = 2'd3;
      default: byte_idx = 2'd0;
    endcase
  end

  // Address/data are pure functions of held state, so they freeze under rdy_in=0.
  assign mem_wr = rdy_in && (state_q != S_IDLE);
  assign mem_a  = waddr_q + {30'd0, byte_idx};
  always_comb begin
    case (byte_idx)
      2'd1:    mem_dout = word_q[15:8];
      2'd2:    mem_dout = word_q[23:16];
      2'd3:    mem_dout = word_q[31:24];
      default: mem_dout = word_q[7:0];
    endcase
  end

  assign busy  = !empty || (state_q != S_IDLE);
  assign err   = err_q;
  assign count = count_q;
endmodule

// File: tb/tb_inst_encoder.sv
// Self-checking bench for inst_encoder: directed scenarios with cycle-exact
// checks plus a randomized stream compared against a table-driven ISA model.
module tb_inst_encoder;
  logic        clk_in = 1'b0, rst_in = 1'b1, rdy_in = 1'b1, start = 1'b0;
  logic [31:0] base_addr = '0, imm = '0;
  logic        in_valid = 1'b0;
  logic        in_ready, mem_wr, busy, err;
  logic [5:0]  op_type = '0;
  logic [4:0]  rd = '0, rs1 = '0, rs2 = '0;
  logic [31:0] mem_a;
  logic [7:0]  mem_dout;
  logic [15:0] count;

  int checks = 0, errors = 0;
  logic [31:0] mon_a[$];
  logic [7:0]  mon_d[$];
  logic [31:0] exp_q[$];
  int run_len = 0, max_run = 0;
  bit saw_full = 0;

  inst_encoder #(.FIFO_DEPTH(2)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .start(start),
    .base_addr(base_addr), .in_valid(in_valid), .in_ready(in_ready),
    .op_type(op_type), .rd(rd), .rs1(rs1), .rs2(rs2), .imm(imm),
    .mem_wr(mem_wr), .mem_a(mem_a), .mem_dout(mem_dout),
    .busy(busy), .err(err), .count(count));

  always #5 clk_in = ~clk_in;

  initial begin
    #2000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  always @(negedge clk_in) begin
    if (mem_wr) begin
      mon_a.push_back(mem_a);
      mon_d.push_back(mem_dout);
      run_len++;
      if (run_len > max_run) max_run = run_len;
    end else run_len = 0;
    if (!rst_in && rdy_in && !start && !in_ready) saw_full = 1;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // ISA reference: format letter and funct3 digit per OP code
  function automatic logic [32:0] ref_enc(input logic [5:0] op, input logic [4:0] d,
                                          input logic [4:0] s1, input logic [4:0] s2,
                                          input logic [31:0] im);
    string fmt_s = ".UUJjBBBBBBLLLLLSSSIIIIIIHHHRRRRRRRRRR";
    string f3_s  = "00000014567012450120234671550012345567";
    byte c;
    logic [2:0] f3;
    logic [6:0] f7;
    if (op == 0 || op > 37) return {1'b0, 32'h0};
    c  = fmt_s[int'(op)];
    f3 = 3'(f3_s[int'(op)] - 8'd48);
    f7 = (op == 27 || op == 29 || op == 35) ? 7'b0100000 : 7'b0000000;
    if (c == "U")      return {1'b1, im[31:12], d, (op == 1) ? 7'b0110111 : 7'b0010111};
    else if (c == "J") return {1'b1, im[20], im[10:1], im[11], im[19:12], d, 7'b1101111};
    else if (c == "j") return {1'b1, im[11:0], s1, f3, d, 7'b1100111};
    else if (c == "L") return {1'b1, im[11:0], s1, f3, d, 7'b0000011};
    else if (c == "I") return {1'b1, im[11:0], s1, f3, d, 7'b0010011};
    else if (c == "H") return {1'b1, f7, im[4:0], s1, f3, d, 7'b0010011};
    else if (c == "S") return {1'b1, im[11:5], s2, s1, f3, im[4:0], 7'b0100011};
    else if (c == "B") return {1'b1, im[12], im[10:5], s2, s1, f3, im[4:1], im[11], 7'b1100011};
    else               return {1'b1, f7, s2, s1, f3, d, 7'b0110011};
  endfunction

  task automatic tick();
    @(posedge clk_in); #1;
  endtask

  task automatic do_start(input logic [31:0] b);
    start = 1'b1; base_addr = b;
    tick();
    start = 1'b0;
  endtask

  task automatic set_in(input logic [5:0] o, input logic [4:0] d, input logic [4:0] a,
                        input logic [4:0] bb, input logic [31:0] i);
    op_type = o; rd = d; rs1 = a; rs2 = bb; imm = i;
  endtask

  task automatic push(input logic [5:0] o, input logic [4:0] d, input logic [4:0] a,
                      input logic [4:0] bb, input logic [31:0] i);
    int n = 0;
    set_in(o, d, a, bb, i);
    in_valid = 1'b1;
    @(negedge clk_in);
    while (!in_ready && n < 100) begin @(negedge clk_in); n++; end
    if (n >= 100) chk("push_timeout", 32'(in_ready), 32'd1);
    tick();
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    @(negedge clk_in);
    while (busy && n < 500) begin @(negedge clk_in); n++; end
    chk("drain_busy", 32'(busy), 32'd0);
    tick();
  endtask

  task automatic wait_wr(input logic [31:0] a);
    int n = 0;
    @(negedge clk_in);
    while (!(mem_wr && mem_a == a) && n < 100) begin @(negedge clk_in); n++; end
    if (n >= 100) chk("wait_wr_timeout", mem_a, a);
  endtask

  task automatic clr_mon();
    mon_a.delete(); mon_d.delete();
  endtask

  // Compare captured bytes with exp_q laid out from base
  task automatic check_words(input string tag, input logic [31:0] base);
    logic [31:0] w;
    chk({tag, "_nbytes"}, mon_a.size(), 32'(exp_q.size() * 4));
    for (int i = 0; i < exp_q.size(); i++) begin
      if (4 * i + 3 < mon_a.size()) begin
        w = {mon_d[4*i+3], mon_d[4*i+2], mon_d[4*i+1], mon_d[4*i]};
        chk({tag, "_word"}, w, exp_q[i]);
        for (int k = 0; k < 4; k++)
          chk({tag, "_addr"}, mon_a[4*i+k], base + 32'(4 * i + k));
      end
    end
  endtask

  initial begin
    logic [31:0] w_addi;
    logic [32:0] r;
    logic [31:0] rbase;
    int n_inv;

    w_addi = 32'h00500093;
    repeat (2) @(posedge clk_in);
    @(negedge clk_in);
    chk("rst_mem_wr", 32'(mem_wr), 0);
    chk("rst_mem_a", mem_a, 0);
    chk("rst_mem_dout", 32'(mem_dout), 0);
    chk("rst_count", 32'(count), 0);
    chk("rst_err", 32'(err), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_in_ready", 32'(in_ready), 1);
    tick();
    rst_in = 1'b0;

    // single ADDI, cycle-exact
    do_start(32'h1000);
    clr_mon();
    set_in(6'd19, 5'd1, 5'd0, 5'd0, 32'd5);
    in_valid = 1'b1;
    @(negedge clk_in);
    chk("t1_in_ready", 32'(in_ready), 1);
    tick();
    in_valid = 1'b0;
    @(negedge clk_in);
    chk("t1_c1_mem_wr", 32'(mem_wr), 0);
    chk("t1_c1_busy", 32'(busy), 1);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk_in);
      chk("t1_mem_wr", 32'(mem_wr), 1);
      chk("t1_mem_a", mem_a, 32'h1000 + 32'(k));
      chk("t1_mem_dout", 32'(mem_dout), 32'(w_addi[8*k +: 8]));
    end
    tick();
    chk("t1_count", 32'(count), 1);

    // back-to-back stream
    drain();
    do_start(32'h2000);
    clr_mon(); max_run = 0; saw_full = 0;
    push(6'd1,  5'd2, 5'd0, 5'd0, 32'h12345000);
    push(6'd27, 5'd3, 5'd3, 5'd0, 32'd4);
    push(6'd3,  5'd1, 5'd0, 5'd0, 32'hFFFFFFFC);
    push(6'd18, 5'd0, 5'd2, 5'd5, 32'd8);
    drain();
    exp_q = '{32'h12345137, 32'h4041D193, 32'hFFDFF0EF, 32'h00512423};
    check_words("t2", 32'h2000);
    chk("t2_run", 32'(max_run), 16);
    chk("t2_full_seen", 32'(saw_full), 1);
    chk("t2_count", 32'(count), 4);

    // invalid op then ADDI
    do_start(32'h3000);
    clr_mon();
    push(6'd0, 5'd7, 5'd7, 5'd7, 32'hFFFF);
    push(6'd19, 5'd1, 5'd0, 5'd0, 32'd5);
    drain();
    exp_q = '{w_addi};
    check_words("t3", 32'h3000);
    chk("t3_err", 32'(err), 1);
    chk("t3_count", 32'(count), 1);

    // start during W1 with a second entry queued; in_valid alongside start
    push(6'd19, 5'd1, 5'd0, 5'd0, 32'd5);
    push(6'd1,  5'd2, 5'd0, 5'd0, 32'h12345000);
    wait_wr(32'h3005);
    start = 1'b1; base_addr = 32'h5000;
    in_valid = 1'b1;
    #1;
    chk("t4_in_ready_start", 32'(in_ready), 0);
    tick();
    start = 1'b0; in_valid = 1'b0;
    clr_mon();
    @(negedge clk_in);
    chk("t4_mem_wr", 32'(mem_wr), 0);
    chk("t4_busy", 32'(busy), 0);
    chk("t4_count", 32'(count), 0);
    chk("t4_err", 32'(err), 0);
    repeat (8) tick();
    chk("t4_no_writes", mon_a.size(), 0);
    push(6'd19, 5'd1, 5'd0, 5'd0, 32'd5);
    drain();
    exp_q = '{w_addi};
    check_words("t4", 32'h5000);
    chk("t4_count2", 32'(count), 1);

    // rdy_in pause during W2
    do_start(32'h6000);
    clr_mon();
    push(6'd18, 5'd0, 5'd2, 5'd5, 32'd8);
    wait_wr(32'h6001);
    tick();
    rdy_in = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk_in);
      chk("t5_pause_wr", 32'(mem_wr), 0);
      chk("t5_pause_a", mem_a, 32'h6002);
      chk("t5_pause_d", 32'(mem_dout), 32'h51);
      tick();
    end
    rdy_in = 1'b1;
    drain();
    exp_q = '{32'h00512423};
    check_words("t5", 32'h6000);
    chk("t5_count", 32'(count), 1);

    // address wrap
    do_start(32'hFFFFFFFC);
    clr_mon();
    push(6'd19, 5'd1, 5'd0, 5'd0, 32'd5);
    push(6'd1,  5'd2, 5'd0, 5'd0, 32'h12345000);
    drain();
    exp_q = '{w_addi, 32'h12345137};
    check_words("t6", 32'hFFFFFFFC);

    // randomized stream with pauses and invalid codes
    rbase = $urandom;
    do_start(rbase);
    clr_mon();
    exp_q.delete();
    n_inv = 0;
    for (int c = 0; c < 400; c++) begin
      rdy_in   = ($urandom_range(0, 5) != 0);
      in_valid = ($urandom_range(0, 2) != 0);
      set_in(($urandom_range(0, 3) != 0) ? 6'($urandom_range(1, 37)) : 6'($urandom_range(0, 63)),
             5'($urandom), 5'($urandom), 5'($urandom), $urandom);
      @(negedge clk_in);
      if (in_valid && in_ready) begin
        r = ref_enc(op_type, rd, rs1, rs2, imm);
        if (r[32]) exp_q.push_back(r[31:0]);
        else n_inv++;
      end
      tick();
    end
    in_valid = 1'b0; rdy_in = 1'b1;
    drain();
    check_words("rnd", rbase);
    chk("rnd_count", 32'(count), 32'(exp_q.size() & 16'hFFFF));
    chk("rnd_err", 32'(err), 32'(n_inv > 0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
